// File: rtl/ppi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ppi_pkg                                                           |
// | Brief  : Shared address map, reset control word and FSM encoding for PPI.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package ppi_pkg;

    localparam logic [1:0] PA   = 2'd0;
    localparam logic [1:0] PB   = 2'd1;
    localparam logic [1:0] PC   = 2'd2;
    localparam logic [1:0] CTRL = 2'd3;

    localparam logic [7:0] CW_RESET = 8'h9B;

    typedef logic [1:0] ppi_state_t;

    localparam ppi_state_t ST_IDLE   = 2'd0;
    localparam ppi_state_t ST_WR_ACT = 2'd1;
    localparam ppi_state_t ST_COMMIT = 2'd2;
    localparam ppi_state_t ST_RD_ACT = 2'd3;

    // One-hot {PC,PB,PA}; the control register has no port strobe.
    function automatic logic [2:0] port_onehot(input logic [1:0] i_a);
        logic [2:0] w_oh;
        case (i_a)
            PA:      w_oh = 3'b001;
            PB:      w_oh = 3'b010;
            PC:      w_oh = 3'b100;
            default: w_oh = 3'b000;
        endcase
        return w_oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppi_ctrl_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ppi_ctrl_reg_if                                                   |
// | Brief  : CPU-side bus of the PPI control block (strobes, address, data).   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface ppi_ctrl_reg_if;

    logic       nCs;
    logic       nRd;
    logic       nWr;
    logic [1:0] A;
    logic [7:0] D;

    modport master (
        output nCs,
        output nRd,
        output nWr,
        output A,
        output D
    );

    modport slave (
        input nCs,
        input nRd,
        input nWr,
        input A,
        input D
    );

endinterface
`default_nettype wire

// File: rtl/ppi_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ppi_sync                                                          |
// | Brief  : Parameterized-width 2-flop synchronizer with per-bit reset value. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module ppi_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/ppi_ctrl_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ppi_ctrl_reg                                                      |
// | Brief  : PPI bus decoder: synchronizes CPU strobes, commits port writes,   |
// |          control-word loads and bit set/reset commands, tracks reads.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module ppi_ctrl_reg
    import ppi_pkg::*;
(
    input  logic                 clk,
    input  logic                 Reset,
    ppi_ctrl_reg_if.slave        bus,
    output logic [7:0]           controlword,
    output logic [5:0]           control,
    output logic [2:0]           wr_port,
    output logic [7:0]           wr_data,
    output logic [2:0]           rd_port,
    output logic                 bsr_valid,
    output logic [2:0]           bsr_bit,
    output logic                 bsr_val,
    output logic                 mode_set,
    output logic                 bus_err
);

    localparam logic [4:0] c_SYNC_RESET = {3'b111, 2'b00};

    logic [4:0]  w_sync_in;
    logic [4:0]  w_sync_out;
    logic        w_ncs_s;
    logic        w_nrd_s;
    logic        w_nwr_s;
    logic [1:0]  w_a_s;

    ppi_state_t  r_state;
    ppi_state_t  w_state_nxt;
    logic        w_conflict;
    logic        w_wr_latch;
    logic        w_rd_start;
    logic        w_commit;

    logic [1:0]  r_lat_a;
    logic [7:0]  r_lat_d;
    logic [1:0]  r_settle;
    logic        r_wr_armed;

    logic [7:0]  r_cw;
    logic [2:0]  r_wr_port;
    logic [7:0]  r_wr_data;
    logic        r_bsr_valid;
    logic [2:0]  r_bsr_bit;
    logic        r_bsr_val;
    logic        r_mode_set;
    logic        r_bus_err;

    assign w_sync_in = {bus.nCs, bus.nRd, bus.nWr, bus.A};

    ppi_sync #(
        .WIDTH     (5),
        .RESET_VAL (c_SYNC_RESET)
    ) u_sync (
        .clk (clk),
        .rst (Reset),
        .i_d (w_sync_in),
        .o_q (w_sync_out)
    );

    assign {w_ncs_s, w_nrd_s, w_nwr_s, w_a_s} = w_sync_out;

    assign w_conflict = !w_ncs_s && !w_nrd_s && !w_nwr_s;

    always_comb begin
        w_state_nxt = r_state;
        w_wr_latch  = 1'b0;
        w_rd_start  = 1'b0;
        w_commit    = 1'b0;
        if (w_conflict) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_ncs_s && !w_nwr_s && w_nrd_s && r_wr_armed) begin
                        w_state_nxt = ST_WR_ACT;
                        w_wr_latch  = 1'b1;
                    end else if (!w_ncs_s && !w_nrd_s && w_nwr_s && (w_a_s != CTRL)) begin
                        w_state_nxt = ST_RD_ACT;
                        w_rd_start  = 1'b1;
                    end
                end
                ST_WR_ACT: begin
                    if (w_nwr_s) begin
                        w_state_nxt = ST_COMMIT;
                        w_commit    = 1'b1;
                    end else if (w_ncs_s) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_wr_latch  = 1'b1;
                    end
                end
                ST_COMMIT: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_RD_ACT: begin
                    if (w_nrd_s || w_ncs_s) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // A write only arms once nWr has been seen high with the synchronizer
    // carrying real pin data, so a strobe held low across reset never commits.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_lat_a    <= 2'b00;
            r_lat_d    <= 8'h00;
            r_settle   <= 2'b00;
            r_wr_armed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_settle <= {r_settle[0], 1'b1};
            if (r_settle[1] && w_nwr_s) begin
                r_wr_armed <= 1'b1;
            end
            if (w_wr_latch || w_rd_start) begin
                r_lat_a <= w_a_s;
            end
            if (w_wr_latch) begin
                r_lat_d <= bus.D;
            end
        end
    end

    // Commit results register on the edge that enters COMMIT, so they are
    // visible for exactly the COMMIT cycle.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_cw        <= CW_RESET;
            r_wr_port   <= 3'b000;
            r_wr_data   <= 8'h00;
            r_bsr_valid <= 1'b0;
            r_bsr_bit   <= 3'd0;
            r_bsr_val   <= 1'b0;
            r_mode_set  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_wr_port   <= 3'b000;
            r_bsr_valid <= 1'b0;
            r_mode_set  <= 1'b0;
            if (w_commit) begin
                if (r_lat_a != CTRL) begin
                    r_wr_port <= port_onehot(r_lat_a);
                    r_wr_data <= r_lat_d;
                end else if (r_lat_d[7]) begin
                    r_cw       <= r_lat_d;
                    r_mode_set <= 1'b1;
                end else if (r_cw[7]) begin
                    r_bsr_valid <= 1'b1;
                    r_bsr_bit   <= r_lat_d[3:1];
                    r_bsr_val   <= r_lat_d[0];
                end
            end
            if (w_conflict) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign controlword = r_cw;
    assign control     = {w_ncs_s, w_nrd_s, w_nwr_s, Reset, w_a_s};
    assign wr_port     = r_wr_port;
    assign wr_data     = r_wr_data;
    assign rd_port     = (r_state == ST_RD_ACT) ? port_onehot(r_lat_a) : 3'b000;
    assign bsr_valid   = r_bsr_valid;
    assign bsr_bit     = r_bsr_bit;
    assign bsr_val     = r_bsr_val;
    assign mode_set    = r_mode_set;
    assign bus_err     = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_ppi_ctrl_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ppi_ctrl_reg                                                   |
// | Brief  : Self-checking bench: vector table, random traffic, corner cases.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ppi_ctrl_reg;

    logic       clk = 1'b0;
    logic       Reset;
    logic [7:0] controlword;
    logic [5:0] control;
    logic [2:0] wr_port;
    logic [7:0] wr_data;
    logic [2:0] rd_port;
    logic       bsr_valid;
    logic [2:0] bsr_bit;
    logic       bsr_val;
    logic       mode_set;
    logic       bus_err;

    always #5 clk = ~clk;

    ppi_ctrl_reg_if bus ();

    ppi_ctrl_reg dut (
        .clk         (clk),
        .Reset       (Reset),
        .bus         (bus),
        .controlword (controlword),
        .control     (control),
        .wr_port     (wr_port),
        .wr_data     (wr_data),
        .rd_port     (rd_port),
        .bsr_valid   (bsr_valid),
        .bsr_bit     (bsr_bit),
        .bsr_val     (bsr_val),
        .mode_set    (mode_set),
        .bus_err     (bus_err)
    );

    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
        logic [2:0] e_wp;
        logic [7:0] e_wd;
        logic       e_mode;
        logic       e_bsr;
        logic [2:0] e_bit;
        logic       e_val;
        logic [7:0] e_cw;
    } vec_t;

    vec_t tbl [9];

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural state of the register file.
    logic [7:0] m_cw;
    logic [2:0] m_bit;
    logic       m_val;

    logic [2:0] cap_wp;
    logic [7:0] cap_wd;
    logic       cap_mode;
    logic       cap_bsr;
    logic [2:0] cap_bit;
    logic       cap_val;
    logic [7:0] cap_cw;
    logic [2:0] cap_extra;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write cycle; results sampled on each cycle after nWr rises,
    // commit expected on the third.
    task automatic do_write(input logic [1:0] a, input logic [7:0] d, input int hold);
        tick();
        bus.A   = a;
        bus.D   = d;
        bus.nCs = 1'b0;
        tick();
        bus.nWr = 1'b0;
        repeat (hold) tick();
        bus.nWr   = 1'b1;
        cap_extra = 3'b000;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 3) begin
                cap_wp   = wr_port;
                cap_wd   = wr_data;
                cap_mode = mode_set;
                cap_bsr  = bsr_valid;
                cap_bit  = bsr_bit;
                cap_val  = bsr_val;
                cap_cw   = controlword;
            end else begin
                cap_extra = cap_extra | {|wr_port, mode_set, bsr_valid};
            end
        end
        bus.nCs = 1'b1;
        repeat (3) tick();
    endtask

    task automatic check_write(input string nm, input logic [2:0] e_wp, input logic [7:0] e_wd,
                               input logic e_mode, input logic e_bsr, input logic [2:0] e_bit,
                               input logic e_val, input logic [7:0] e_cw);
        check({nm, ".wr_port"}, cap_wp, e_wp);
        if (e_wp != 3'b000) check({nm, ".wr_data"}, cap_wd, e_wd);
        check({nm, ".mode_set"},  cap_mode, e_mode);
        check({nm, ".bsr_valid"}, cap_bsr,  e_bsr);
        check({nm, ".bsr_bit"},   cap_bit,  e_bit);
        check({nm, ".bsr_val"},   cap_val,  e_val);
        check({nm, ".cw"},        cap_cw,   e_cw);
        check({nm, ".stray_pulse"}, cap_extra, 3'b000);
    endtask

    // Model-driven write: expectations follow directly from the register map.
    task automatic model_write(input string nm, input logic [1:0] a, input logic [7:0] d, input int hold);
        logic [2:0] e_wp;
        logic       e_mode;
        logic       e_bsr;
        e_wp   = (a == 2'd3) ? 3'b000 : (3'b001 << a);
        e_mode = (a == 2'd3) && d[7];
        e_bsr  = (a == 2'd3) && !d[7] && m_cw[7];
        if (e_mode) m_cw = d;
        if (e_bsr) begin
            m_bit = d[3:1];
            m_val = d[0];
        end
        do_write(a, d, hold);
        check_write(nm, e_wp, d, e_mode, e_bsr, m_bit, m_val, m_cw);
    endtask

    task automatic do_read(input string nm, input logic [1:0] a, input int hold);
        logic [2:0] e_rd;
        int         n_wrong;
        logic [2:0] after;
        e_rd    = (a == 2'd3) ? 3'b000 : (3'b001 << a);
        n_wrong = 0;
        after   = 3'b000;
        tick();
        bus.A   = a;
        bus.nCs = 1'b0;
        tick();
        bus.nRd = 1'b0;
        for (int k = 1; k <= hold; k++) begin
            tick();
            if ((k >= 3 || a == 2'd3) && rd_port !== e_rd) n_wrong++;
        end
        bus.nRd = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k >= 3) after = after | rd_port;
        end
        check({nm, ".during_bad_cycles"}, n_wrong, 0);
        check({nm, ".after_release"}, after, 3'b000);
        bus.nCs = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] acc;
        bus.nCs = 1'b1;
        bus.nRd = 1'b1;
        bus.nWr = 1'b1;
        bus.A   = 2'd0;
        bus.D   = 8'h00;
        Reset   = 1'b1;
        repeat (2) tick();

        check("rst.controlword", controlword, 8'h9B);
        check("rst.wr_port",     wr_port,     3'b000);
        check("rst.rd_port",     rd_port,     3'b000);
        check("rst.wr_data",     wr_data,     8'h00);
        check("rst.bsr",         {bsr_valid, bsr_bit, bsr_val}, 5'b0);
        check("rst.mode_set",    mode_set,    1'b0);
        check("rst.bus_err",     bus_err,     1'b0);
        check("rst.control",     control,     6'b111100);

        Reset = 1'b0;
        repeat (4) tick();
        check("idle.control", control, 6'b111000);

        tbl[0] = '{2'd3, 8'h80, 3'b000, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h80};
        tbl[1] = '{2'd3, 8'h0B, 3'b000, 8'h00, 1'b0, 1'b1, 3'd5, 1'b1, 8'h80};
        tbl[2] = '{2'd1, 8'h5A, 3'b010, 8'h5A, 1'b0, 1'b0, 3'd5, 1'b1, 8'h80};
        tbl[3] = '{2'd0, 8'hC3, 3'b001, 8'hC3, 1'b0, 1'b0, 3'd5, 1'b1, 8'h80};
        tbl[4] = '{2'd2, 8'h01, 3'b100, 8'h01, 1'b0, 1'b0, 3'd5, 1'b1, 8'h80};
        tbl[5] = '{2'd3, 8'h0A, 3'b000, 8'h00, 1'b0, 1'b1, 3'd5, 1'b0, 8'h80};
        tbl[6] = '{2'd3, 8'hF0, 3'b000, 8'h00, 1'b1, 1'b0, 3'd5, 1'b0, 8'hF0};
        tbl[7] = '{2'd3, 8'h07, 3'b000, 8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 8'hF0};
        tbl[8] = '{2'd3, 8'h9B, 3'b000, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h9B};

        for (int i = 0; i < 9; i++) begin
            do_write(tbl[i].a, tbl[i].d, 1 + (i % 3));
            check_write($sformatf("vec%0d", i), tbl[i].e_wp, tbl[i].e_wd, tbl[i].e_mode,
                        tbl[i].e_bsr, tbl[i].e_bit, tbl[i].e_val, tbl[i].e_cw);
        end
        m_cw  = 8'h9B;
        m_bit = 3'd3;
        m_val = 1'b1;

        do_read("read_pc", 2'd2, 7);
        do_read("read_ctrl", 2'd3, 6);

        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op < 2) begin
                model_write($sformatf("rnd%0d_wr", i), 2'($urandom_range(0, 3)),
                            8'($urandom), $urandom_range(1, 4));
            end else begin
                do_read($sformatf("rnd%0d_rd", i), 2'($urandom_range(0, 3)), $urandom_range(4, 7));
            end
        end

        // Read and write strobes asserted together.
        acc = 3'b000;
        tick();
        bus.A   = 2'd1;
        bus.D   = 8'hAA;
        bus.nCs = 1'b0;
        tick();
        bus.nRd = 1'b0;
        bus.nWr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            acc = acc | wr_port;
        end
        bus.nRd = 1'b1;
        bus.nWr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            acc = acc | wr_port;
        end
        bus.nCs = 1'b1;
        repeat (3) tick();
        check("conflict.bus_err", bus_err, 1'b1);
        check("conflict.no_commit", acc, 3'b000);
        model_write("post_conflict", 2'd0, 8'h77, 2);
        check("conflict.sticky", bus_err, 1'b1);

        // Reset pulsed while a write to PA is in flight.
        acc = 3'b000;
        tick();
        bus.A   = 2'd0;
        bus.D   = 8'h55;
        bus.nCs = 1'b0;
        tick();
        bus.nWr = 1'b0;
        repeat (4) tick();
        Reset = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            acc = acc | wr_port;
        end
        m_cw  = 8'h9B;
        m_bit = 3'd0;
        m_val = 1'b0;
        check("rstwr.controlword", controlword, 8'h9B);
        check("rstwr.bus_err", bus_err, 1'b0);
        bus.nWr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            acc = acc | wr_port;
        end
        check("rstwr.no_commit", acc, 3'b000);
        bus.nCs = 1'b1;
        repeat (3) tick();
        model_write("rstwr.fresh", 2'd2, 8'h3C, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
